// File: rtl/fixed_point_pkg.sv
// ============================================================================
// Module  : fixed_point_pkg
// Brief   : Shared types and constant helpers for the fixed-point accumulator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fixed_point_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

  // Wide enough to carry any practical bound before being cast to its target width.
  localparam int BOUND_W = 128;
  typedef logic [BOUND_W-1:0] wide_t;

  function automatic int calc_width(input int sign, input int q_m, input int q_n);
    return sign + q_m + q_n;
  endfunction

  function automatic int guard_bits(input int n_terms);
    return $clog2(n_terms + 1);
  endfunction

  function automatic wide_t bound_max(input int sign, input int w);
    if (sign != 0) return (wide_t'(1) << (w - 1)) - wide_t'(1);
    else           return (wide_t'(1) << w) - wide_t'(1);
  endfunction

  function automatic wide_t bound_min(input int sign, input int w);
    if (sign != 0) return ~((wide_t'(1) << (w - 1)) - wide_t'(1));
    else           return '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fixed_point_saturate.sv
// ============================================================================
// Module  : fixed_point_saturate
// Brief   : Narrows a wide fixed-point value, clamping or wrapping, and flags overflow.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fixed_point_saturate
  import fixed_point_pkg::*;
#(
  parameter int SIGN     = 1,
  parameter int IN_W     = 36,
  parameter int OUT_W    = 33,
  parameter int SATURATE = 1
) (
  input  logic [IN_W-1:0]  val_i,
  output logic [OUT_W-1:0] val_o,
  output logic             overflow_o
);

  localparam logic [IN_W-1:0]  MAX_I = IN_W'(bound_max(SIGN, OUT_W));
  localparam logic [OUT_W-1:0] MAX_O = OUT_W'(bound_max(SIGN, OUT_W));

  logic             w_hi;
  logic             w_lo;
  logic [OUT_W-1:0] w_bound;

  generate
    if (SIGN != 0) begin : g_signed
      localparam logic [IN_W-1:0]  MIN_I = IN_W'(bound_min(SIGN, OUT_W));
      localparam logic [OUT_W-1:0] MIN_O = OUT_W'(bound_min(SIGN, OUT_W));
      assign w_hi    = $signed(val_i) > $signed(MAX_I);
      assign w_lo    = $signed(val_i) < $signed(MIN_I);
      assign w_bound = w_hi ? MAX_O : MIN_O;
    end else begin : g_unsigned
      assign w_hi    = val_i > MAX_I;
      assign w_lo    = 1'b0;
      assign w_bound = MAX_O;
    end
  endgenerate

  assign overflow_o = w_hi | w_lo;
  assign val_o      = ((SATURATE != 0) && overflow_o) ? w_bound : val_i[OUT_W-1:0];

endmodule

`default_nettype wire

// File: rtl/fixed_point_accumulator.sv
// ============================================================================
// Module  : fixed_point_accumulator
// Brief   : Streams bias + N_TERMS Qm.n operands into a guarded accumulator.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fixed_point_accumulator
  import fixed_point_pkg::*;
#(
  parameter int   SIGN     = 1,
  parameter int   Q_M      = 16,
  parameter int   Q_N      = 16,
  parameter int   N_TERMS  = 4,
  parameter int   SATURATE = 1,
  localparam int  W        = calc_width(SIGN, Q_M, Q_N)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_in,
  input  logic         abort_in,
  input  logic [W-1:0] b_in,
  input  logic         term_valid_in,
  output logic         term_ready_out,
  input  logic [W-1:0] term_in,
  output logic         y_valid_out,
  input  logic         y_ready_in,
  output logic [W-1:0] y_out,
  output logic         overflow_out,
  output logic         busy_out
);

  localparam int G     = guard_bits(N_TERMS);
  localparam int ACC_W = W + G;
  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] w_sum;
  logic [W-1:0]     w_fmt;
  logic             w_ovf;
  logic             w_term_hs;
  logic             w_last;

  function automatic logic [ACC_W-1:0] ext(input logic [W-1:0] v);
    if (SIGN != 0) return {{G{v[W-1]}}, v};
    else           return {{G{1'b0}}, v};
  endfunction

  assign w_sum     = acc_q + ext(term_in);
  assign w_term_hs = term_valid_in & term_ready_out;
  assign w_last    = (cnt_q == LAST_CNT);

  fixed_point_saturate #(
    .SIGN     (SIGN),
    .IN_W     (ACC_W),
    .OUT_W    (W),
    .SATURATE (SATURATE)
  ) u_fmt (
    .val_i      (w_sum),
    .val_o      (w_fmt),
    .overflow_o (w_ovf)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      ovf_q     <= ovf_d;
    end
  end

  // Abort outranks start and both handshakes in every non-idle state.
  always_comb begin
    state_d = state_q;
    if (abort_in && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_in) state_d = ACCUM;
        ACCUM:   if (w_term_hs && w_last) state_d = DONE;
        DONE:    if (y_ready_in) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    ovf_d     = ovf_q;
    if (abort_in && (state_q != IDLE)) begin
      y_valid_d = 1'b0;
      ovf_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_in) begin
            acc_d = ext(b_in);
            cnt_d = '0;
          end
        end
        ACCUM: begin
          if (w_term_hs) begin
            acc_d = w_sum;
            cnt_d = cnt_q + CNT_W'(1);
            if (w_last) begin
              y_d       = w_fmt;
              ovf_d     = w_ovf;
              y_valid_d = 1'b1;
            end
          end
        end
        DONE: begin
          if (y_ready_in) y_valid_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    term_ready_out = (state_q == ACCUM);
    busy_out       = (state_q != IDLE);
    y_valid_out    = y_valid_q;
    y_out          = y_q;
    overflow_out   = ovf_q;
  end

endmodule

`default_nettype wire
